// File: rtl/phase_tx_serializer.sv
// Byte-to-chip serializer: FIFO-buffered bytes sent LSB first, each bit held N clocks.
// Ports: i_clk, i_rst (async, active-low), i_data/i_valid/o_ready byte input,
//        i_nb_P chip period, o_phase serial out, o_strobe chip start, o_busy in SEND.
// Optional: define PHASE_TX_DIFF_EN for differential chip encoding.
module phase_tx_serializer #(
    parameter logic IDLE_PHASE = 1'b0,
    parameter int   FIFO_DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [5:0] i_nb_P,
    output logic       o_phase,
    output logic       o_strobe,
    output logic       o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t state_q, state_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic          push, pop, empty;

    logic [5:0] n_q, cnt_q, n_eff;
    logic [2:0] idx_q;
    logic [7:0] sh_q;
    logic       phase_q;
    logic       load, shift, go_idle;
    logic       nbit, chip;

    assign empty   = (count_q == '0);
    assign o_ready = (count_q != FULL);
    assign push    = i_valid && o_ready;
    assign pop     = load;
    assign n_eff   = (i_nb_P < 6'd2) ? 6'd2 : i_nb_P;

    // Next bit to present: head of FIFO on load, else next shift position.
    assign nbit = load ? mem[rd_ptr][0] : sh_q[1];

`ifdef PHASE_TX_DIFF_EN
    logic diff_q;
    assign chip = diff_q ^ nbit;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            diff_q <= IDLE_PHASE;
        end else if (load || shift) begin
            diff_q <= chip;
        end
    end
`else
    assign chip = nbit;
`endif

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        go_idle = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (cnt_q == n_q - 6'd1) begin
                    if (idx_q != 3'd7) begin
                        shift = 1'b1;
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sh_q    <= '0;
            n_q     <= 6'd2;
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= IDLE_PHASE;
        end else if (load) begin
            sh_q    <= mem[rd_ptr];
            n_q     <= n_eff;
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= chip;
        end else if (shift) begin
            sh_q    <= sh_q >> 1;
            cnt_q   <= '0;
            idx_q   <= idx_q + 3'd1;
            phase_q <= chip;
        end else if (go_idle) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= IDLE_PHASE;
        end else if (state_q == S_SEND) begin
            cnt_q   <= cnt_q + 6'd1;
        end
    end

    assign o_phase  = phase_q;
    assign o_busy   = (state_q == S_SEND);
    assign o_strobe = (state_q == S_SEND) && (cnt_q == '0);

endmodule

// File: tb/tb_phase_tx_serializer.sv
// Scoreboard bench for phase_tx_serializer: stimulus queues expected chips,
// a negedge monitor pops and checks each chip level and length.
module tb_phase_tx_serializer;

    localparam logic IDLE_PHASE = 1'b0;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_data = '0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [5:0] i_nb_P = 6'd5;
    logic       o_phase;
    logic       o_strobe;
    logic       o_busy;

    phase_tx_serializer #(
        .IDLE_PHASE(IDLE_PHASE),
        .FIFO_DEPTH(2)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_nb_P  (i_nb_P),
        .o_phase (o_phase),
        .o_strobe(o_strobe),
        .o_busy  (o_busy)
    );

    always #10 i_clk = ~i_clk;

    typedef struct {
        logic ph;
        int   n;
    } chip_t;

    chip_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  m_prev = IDLE_PHASE;

    int    bursts = 0;
    int    last_busy = 0;
    int    busy_run = 0;
    int    run = 0;
    int    cur_n = 0;
    logic  cur_ph = 1'b0;
    bit    in_chip = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input int n);
        int tries;
        tries = 0;
        i_data  = d;
        i_valid = 1'b1;
        while (!o_ready && tries < 200) begin
            @(posedge i_clk);
            #1;
            tries++;
        end
        chk(o_ready, "push_ready_timeout", int'(o_ready), 1);
        @(posedge i_clk);
        for (int i = 0; i < 8; i++) begin
            chip_t e;
`ifdef PHASE_TX_DIFF_EN
            e.ph   = m_prev ^ d[i];
            m_prev = e.ph;
`else
            e.ph = d[i];
`endif
            e.n = n;
            exp_q.push_back(e);
        end
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_burst(input int b0, input int exp_len, input string name);
        int k;
        k = 0;
        while (bursts == b0 && k < 400) begin
            @(negedge i_clk);
            #1;
            k++;
        end
        chk(bursts != b0, {name, "_timeout"}, k, 400);
        chk(last_busy == exp_len, {name, "_send_len"}, last_busy, exp_len);
        @(posedge i_clk);
        #1;
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            exp_q.delete();
            in_chip  = 0;
            busy_run = 0;
            run      = 0;
        end else if (o_busy) begin
            busy_run++;
            if (o_strobe) begin
                if (in_chip) chk(run == cur_n, "chip_len", run, cur_n);
                chk(exp_q.size() != 0, "unexpected_chip", exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    chip_t e;
                    e = exp_q.pop_front();
                    chk(o_phase == e.ph, "chip_phase", int'(o_phase), int'(e.ph));
                    cur_n  = e.n;
                    cur_ph = e.ph;
                end
                run     = 1;
                in_chip = 1;
            end else begin
                run++;
                chk(in_chip && o_phase == cur_ph, "chip_hold", int'(o_phase), int'(cur_ph));
            end
        end else begin
            if (in_chip) begin
                chk(run == cur_n, "last_chip_len", run, cur_n);
                last_busy = busy_run;
                bursts++;
            end
            in_chip  = 0;
            busy_run = 0;
            chk(o_phase == IDLE_PHASE && !o_strobe, "idle_out", int'(o_phase), int'(IDLE_PHASE));
        end
    end

    initial begin
        int b0;
        int cnt;

        repeat (3) @(negedge i_clk);
        chk(o_phase == IDLE_PHASE, "rst_phase", int'(o_phase), int'(IDLE_PHASE));
        chk(!o_busy, "rst_busy", int'(o_busy), 0);
        chk(!o_strobe, "rst_strobe", int'(o_strobe), 0);
        chk(o_ready, "rst_ready", int'(o_ready), 1);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        // 0xA5 at period 5, with first-chip latency check
        i_nb_P = 6'd5;
        b0 = bursts;
        push(8'hA5, 5);
        @(posedge i_clk);
        #1;
        chk(o_strobe, "lat_strobe", int'(o_strobe), 1);
        chk(o_busy, "lat_busy", int'(o_busy), 1);
        wait_burst(b0, 40, "a5");

        // three back-to-back bytes, FIFO fills
        i_nb_P = 6'd4;
        b0 = bursts;
        push(8'h0F, 4);
        push(8'hF0, 4);
        push(8'h33, 4);
        chk(!o_ready, "full_ready", int'(o_ready), 0);
        cnt = 0;
        while (cnt < 100) begin
            @(posedge i_clk);
            #1;
            cnt++;
            if (o_ready) break;
        end
        chk(cnt == 31, "ready_reopen", cnt, 31);
        wait_burst(b0, 96, "three");

        // minimum period clamp
        i_nb_P = 6'd0;
        b0 = bursts;
        push(8'h01, 2);
        wait_burst(b0, 16, "nb0");
        i_nb_P = 6'd1;
        b0 = bursts;
        push(8'h01, 2);
        wait_burst(b0, 16, "nb1");

        // period change mid-byte applies to next byte only
        i_nb_P = 6'd4;
        b0 = bursts;
        push(8'h55, 4);
        push(8'h55, 8);
        repeat (5) @(posedge i_clk);
        #1;
        i_nb_P = 6'd8;
        wait_burst(b0, 96, "nbchg");

        i_nb_P = 6'd2;
        b0 = bursts;
        push(8'hFF, 2);
        wait_burst(b0, 16, "ff");

        // reset in chip 3 with a second byte buffered
        i_nb_P = 6'd4;
        push(8'h3C, 4);
        push(8'hC3, 4);
        repeat (13) @(posedge i_clk);
        #1;
        chk(o_busy, "pre_rst_busy", int'(o_busy), 1);
        i_rst  = 1'b0;
        m_prev = IDLE_PHASE;
        #1;
        chk(o_phase == IDLE_PHASE, "arst_phase", int'(o_phase), int'(IDLE_PHASE));
        chk(!o_busy, "arst_busy", int'(o_busy), 0);
        chk(o_ready, "arst_ready", int'(o_ready), 1);
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        repeat (20) @(posedge i_clk);
        #1;
        chk(!o_busy, "post_rst_quiet", int'(o_busy), 0);
        b0 = bursts;
        push(8'h81, 4);
        wait_burst(b0, 32, "resume");

        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
